mux_nto1_rr: RTL and testbench

- Parametrised, registered N:1 data multiplexer with per-channel valid/ready handshake. Generalises the team's 2:1 combinational mux.
- Adds a runtime-selectable arbitration mode (round-robin, fixed priority, external select) and one output register stage that holds data under backpressure.
- Sits between several producer channels and one shared consumer, e.g. a shared bus or serialiser input.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 66 ++++++
 rtl/mux_nto1_rr.sv | 121 ++++++++++++
 tb/tb_mux_nto1_rr.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared definitions for the N:1 registered multiplexer.
//                Arbitration mode encodings and a clog2 helper that never
//                returns less than 1, so index signals are at least 1 bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic [1:0] MODE_RR   = 2'b00;  // round-robin
    localparam logic [1:0] MODE_PRIO = 2'b01;  // fixed priority, lowest index wins
    localparam logic [1:0] MODE_EXT  = 2'b10;  // external select
    localparam logic [1:0] MODE_NONE = 2'b11;  // reserved, nothing granted

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Finds the first set
//                request bit searching upward from ptr, wrapping at NUM_CH-1.
//                Implemented as a double-width mask-and-find-first: the
//                request vector is duplicated, bits below ptr are masked off,
//                and the lowest surviving bit (mod NUM_CH) is the winner.
//  Ports       : req     [NUM_CH] - request vector
//                ptr     [SEL_W]  - search start index (< NUM_CH)
//                gnt     [NUM_CH] - one-hot grant, zero when no request
//                gnt_idx [SEL_W]  - binary index of the granted channel
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    localparam int c_DBL_W = 2 * NUM_CH;
    localparam int c_IDX_W = SEL_W + 1;   // wide enough to index 0..2*NUM_CH-1

    logic [c_DBL_W-1:0] w_dbl;
    logic [c_DBL_W-1:0] w_masked;
    logic [c_IDX_W-1:0] w_dbl_idx;
    logic               w_found;

    assign w_dbl = {req, req};

    // The upper copy always lies at or above ptr, so any request survives
    // the mask somewhere and wrap-around falls out naturally.
    for (genvar j = 0; j < c_DBL_W; j++) begin : g_mask
        assign w_masked[j] = w_dbl[j] & (c_IDX_W'(j) >= {1'b0, ptr});
    end

    always_comb begin
        w_found   = 1'b0;
        w_dbl_idx = '0;
        for (int j = 0; j < c_DBL_W; j++) begin
            if (!w_found && w_masked[j]) begin
                w_found   = 1'b1;
                w_dbl_idx = c_IDX_W'(j);
            end
        end
    end

    always_comb begin
        if (w_dbl_idx >= c_IDX_W'(NUM_CH))
            gnt_idx = SEL_W'(w_dbl_idx - c_IDX_W'(NUM_CH));
        else
            gnt_idx = SEL_W'(w_dbl_idx);
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_gnt
        assign gnt[k] = w_found & (gnt_idx == SEL_W'(k));
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nto1_rr
//  Description : Registered N:1 data multiplexer with per-channel valid/ready
//                handshake and runtime-selectable arbitration (round-robin,
//                fixed priority, external select). A single output register
//                holds the word under backpressure and can drain and refill
//                in the same cycle for full throughput.
//  Ports       : clk, rst          - clock, async active-high reset
//                mux_mode [2]      - 00 RR, 01 priority, 10 external, 11 none
//                sel [SEL_W]       - channel index for external-select mode
//                mux_in [N*DATA_W] - packed channel data, ch k at k*DATA_W
//                in_valid/in_ready - per-channel handshake (ready is comb.)
//                mux_out, out_valid, out_ch - registered output word/index
//                out_ready         - consumer ready
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mux_mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] mux_in,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        mux_out,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    localparam logic [NUM_CH-1:0] c_ONE = NUM_CH'(1);

    logic [DATA_W-1:0] r_mux_out;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_out_ch;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_load_en;
    logic [NUM_CH-1:0] w_elig;
    logic [SEL_W-1:0]  w_ptr;
    logic [NUM_CH-1:0] w_gnt;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Non-RR modes reuse the round-robin arbiter: priority mode is RR with
    // the pointer pinned at 0, external mode leaves at most one request.
    // A shift by an out-of-range sel yields an empty eligible set.
    always_comb begin
        w_elig = '0;
        w_ptr  = '0;
        case (mux_mode)
            MODE_RR: begin
                w_elig = in_valid;
                w_ptr  = r_rr_ptr;
            end
            MODE_PRIO: w_elig = in_valid;
            MODE_EXT:  w_elig = in_valid & (c_ONE << sel);
            default:   w_elig = '0;
        endcase
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req     (w_elig),
        .ptr     (w_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Grant is only ever set on a valid channel, so a transfer happens
    // exactly when the register can load and someone was granted.
    assign in_ready = w_load_en ? w_gnt : '0;
    assign w_xfer   = w_load_en && (|w_gnt);

    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_gnt[k]) w_data = mux_in[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_mux_out   <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_mux_out   <= w_data;
                r_out_ch    <= w_gnt_idx;
                if (mux_mode == MODE_RR) begin
                    r_rr_ptr <= (w_gnt_idx == SEL_W'(NUM_CH - 1)) ? '0
                                                                  : w_gnt_idx + SEL_W'(1);
                end
            end else if (w_load_en) begin
                // Data and channel index keep their last value.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign mux_out   = r_mux_out;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule : mux_nto1_rr
`default_nettype wire

// File: tb/tb_mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_nto1_rr
//  Description : Scoreboard bench for mux_nto1_rr. A stimulus process drives
//                directed and random traffic, predicts grants with a
//                behavioural model and queues expected output words; a
//                monitor process compares the registered output against the
//                queue. A second 3-channel instance covers out-of-range sel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode, sel;
    logic [31:0] mux_in;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  mux_out;
    logic        out_valid, out_ready;
    logic [1:0]  out_ch;

    logic [1:0]  mode3, sel3;
    logic [23:0] mux_in3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  mux_out3;
    logic        out_valid3, out_ready3;
    logic [1:0]  out_ch3;

    always #5 clk = ~clk;

    mux_nto1_rr #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .mux_mode(mode), .sel(sel), .mux_in(mux_in),
        .in_valid(in_valid), .in_ready(in_ready), .mux_out(mux_out),
        .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready)
    );

    mux_nto1_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst), .mux_mode(mode3), .sel(sel3), .mux_in(mux_in3),
        .in_valid(in_valid3), .in_ready(in_ready3), .mux_out(mux_out3),
        .out_valid(out_valid3), .out_ch(out_ch3), .out_ready(out_ready3)
    );

    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    bit   m_valid;
    int   m_ptr;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: which channel wins under the arbitration rules, -1 if none.
    function automatic int ref_grant(input logic [1:0] md, input logic [1:0] s,
                                     input logic [3:0] v, input int p);
        int k;
        if (md == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                k = (p + i) % 4;
                if (v[k]) return k;
            end
        end else if (md == 2'b01) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i]) return i;
            end
        end else if (md == 2'b10) begin
            if (v[s]) return int'(s);
        end
        return -1;
    endfunction

    task automatic cycle(input logic [1:0] md, input logic [1:0] s, input logic [3:0] v,
                         input logic [31:0] d, input logic ord);
        int         g;
        bit         load;
        logic [3:0] exp_rdy;
        @(posedge clk);
        #1;
        mode = md; sel = s; in_valid = v; mux_in = d; out_ready = ord;
        @(negedge clk);
        g       = ref_grant(md, s, v, m_ptr);
        load    = !m_valid || ord;
        exp_rdy = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_valid);
        if (exp_rdy != 4'b0000) begin
            sb.push_back('{g, d[g*8 +: 8]});
            m_valid = 1'b1;
            if (md == 2'b00) m_ptr = (g + 1) % 4;
        end else if (load) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: whenever a word is presented it must match the oldest
    // expected word; it leaves the queue only when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", mux_out);
                end else begin
                    chk("mux_out", mux_out, sb[0].d);
                    chk("out_ch", out_ch, sb[0].ch);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        mode = 2'b00; sel = 2'b00; mux_in = '0; in_valid = '0; out_ready = 1'b1;
        mode3 = 2'b00; sel3 = 2'b00; mux_in3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
        m_valid = 1'b0; m_ptr = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mux_out", mux_out, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1; rst = 1'b0;

        // 3-channel instance: external select in range, then out of range.
        @(posedge clk); #1;
        mode3 = 2'b10; sel3 = 2'd0; in_valid3 = 3'b111; mux_in3 = 24'h332211;
        @(negedge clk);
        chk("n3_in_ready_sel0", in_ready3, 3'b001);
        @(posedge clk); #1; sel3 = 2'd3;
        @(negedge clk);
        chk("n3_out_valid", out_valid3, 1);
        chk("n3_mux_out", mux_out3, 8'h11);
        chk("n3_in_ready_sel3", in_ready3, 3'b000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n3_out_valid_fall", out_valid3, 0);
        chk("n3_mux_out_hold", mux_out3, 8'h11);
        in_valid3 = '0;

        // Round-robin fairness, all channels valid.
        for (int i = 0; i < 6; i++) cycle(2'b00, 2'b00, 4'hF, 32'h13121110, 1'b1);
        // Round-robin skip and wrap.
        for (int i = 0; i < 4; i++) cycle(2'b00, 2'b00, 4'b1001, 32'h33000030, 1'b1);
        // Fixed priority.
        for (int i = 0; i < 4; i++) cycle(2'b01, 2'b00, 4'b1110, 32'h43424140, 1'b1);
        // External select.
        for (int i = 0; i < 4; i++) cycle(2'b10, 2'd2, 4'hF, 32'h53525150, 1'b1);
        // Reserved mode.
        for (int i = 0; i < 2; i++) cycle(2'b11, 2'd1, 4'hF, 32'h63626160, 1'b1);
        // Backpressure: hold 8'h12, then release.
        cycle(2'b01, 2'b00, 4'b0001, 32'h00000012, 1'b1);
        for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00, 4'b0010, 32'h00003400, 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00, 4'b0010, 32'h00003400, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 7);
            cycle((r < 4) ? 2'b00 : 2'(r - 4), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
        end

        // Reset mid-stream with a word held in the output register.
        for (int i = 0; i < 2; i++) cycle(2'b00, 2'b00, 4'h0, 32'h0, 1'b1);
        cycle(2'b01, 2'b00, 4'b0001, 32'h000000A5, 1'b1);
        cycle(2'b00, 2'b00, 4'h0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mux_out", mux_out, 0);
        chk("midrst_out_ch", out_ch, 0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle(2'b00, 2'b00, 4'hF, 32'h13121110, 1'b1);

        for (int i = 0; i < 200; i++) begin
            cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 1) != 0);
        end

        // Drain and confirm nothing was lost.
        for (int i = 0; i < 4; i++) cycle(2'b00, 2'b00, 4'h0, 32'h0, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_nto1_rr
`default_nettype wire
